dm_jtag_dtm: RTL and testbench
==============================

// Module: dm_jtag_dtm
// PURPOSE
//  JTAG Debug Transport Module: the DMI initiator that drives the debug module's dmi_* responder port.
//  Oversamples JTAG pins on clk, runs the IEEE 1149.1 TAP, exposes IDCODE/DTMCS/DMI/BYPASS.
//  Turns DMI Update-DR scans into single dmi_valid/dmi_ready transactions and returns read data on the next scan.
// PARAMETERS
//  IDCODE       32'h0000_0001  value captured in IDCODE DR (bit0 must be 1)
//  SYNC_STAGES  2              flops per JTAG input synchroniser (>=2)
// PORTS
//  clk         in   1   system clock; all logic on posedge clk
//  resetn      in   1   synchronous active-low reset
//  tck         in   1   JTAG clock, asynchronous, oversampled
//  tms         in   1   JTAG mode select, asynchronous
//  tdi         in   1   JTAG data in, asynchronous
//  tdo         out  1   JTAG data out, registered
//  dmi_valid   out  1   DMI request valid
//  dmi_ready   in   1   DMI responder ready; transfer when valid&&ready
//  dmi_write   out  1   1=write, 0=read
//  dmi_addr    out  7   DM register address
//  dmi_wdata   out  32  write data
//  dmi_rdata   in   32  read data, valid in transfer cycle
// BEHAVIOUR
//  Reset (resetn=0 at posedge clk): TAP=Test-Logic-Reset, IR=5'h01, tdo=0, dmi_valid=0, dmi_write=0,
//   dmi_addr=0, dmi_wdata=0, sticky busy=0, last addr/rdata=0, synchronisers cleared (tck_prev=0).
//  Sync: tck/tms/tdi through SYNC_STAGES flops; tck_rise/tck_fall = 1-cycle pulses from synced tck vs previous.
//   Requires tck high and low each >= SYNC_STAGES+2 clk cycles.
//  tck_rise: sample synced tms/tdi; advance standard 16-state TAP FSM; shift DR/IR in Shift states (LSB first,
//   tdi into MSB). TMS=1 for 5 rises reaches Test-Logic-Reset from any state.
//  tck_fall: tdo <= shift-reg bit0 in Shift-DR/Shift-IR, else 0.
//  Test-Logic-Reset: IR <= 5'h01. Does not abort a DMI transaction in flight.
//  IR 5 bits; Capture-IR loads 5'b00001. Decode: 01 IDCODE(32b), 10 DTMCS(32b), 11 DMI(41b), else BYPASS(1b, captures 0).
//  DTMCS capture: [3:0]=1 version, [9:4]=7 abits, [11:10]=dmistat ({sticky,sticky}: 0 or 3), [14:12]=1 idle, rest 0.
//   Update: bit16 dmireset clears sticky; bit17 dmihardreset clears sticky and drops dmi_valid (abort) next clk.
//  DMI DR layout: [40:34] addr, [33:2] data, [1:0] op.
//   Capture-DR: {last_addr, last_rdata, status}; status=3 if sticky or transaction pending (pending also sets sticky), else 0.
//   Update-DR, op=0: nop. op=1 read / op=2 write: if sticky=0 and idle -> launch; if pending -> set sticky, no launch;
//   if sticky=1 -> ignored. op=3: nop.
//  Master FSM IDLE->REQ on launch (same clk as Update-DR tck_rise): dmi_valid=1, addr/wdata/write latched, held stable.
//   REQ: on dmi_valid&&dmi_ready -> IDLE, dmi_valid=0 next cycle; read captures dmi_rdata into last_rdata;
//   write leaves last_rdata unchanged; last_addr <= dmi_addr on every transfer.
//   Never asserts dmi_valid two consecutive transfers back to back (min one idle cycle).
//  Simultaneous dmihardreset and transfer: transfer completes (data captured), then FSM IDLE; sticky cleared.
//  Widths: no arithmetic; shift counters not needed (shift length set by TAP state sequence).
// TESTING
//  Reset, shift IR=01, Shift-DR 32 bits -> tdo stream equals IDCODE LSB first (0x00000001).
//  IR=10 capture -> DTMCS reads 0x00001071; abits=7, dmistat=0.
//  IR=11 scan {addr=7'h10,data=0x1,op=2} -> one dmi_valid pulse train, dmi_write=1, addr 0x10, wdata 1; next scan status 0.
//  Read op=1 addr 0x04, responder rdata 0xCAFEF00D -> next DMI capture data field 0xCAFEF00D, op 0.
//  Responder stalls ready 50 clk, second scan op=1 -> capture status 3, sticky set; DTMCS bit16 write clears it.
//  resetn low mid-REQ -> dmi_valid=0 next posedge, TAP in Test-Logic-Reset, IR=01; TMS=1x5 alone leaves REQ pending.

Source files
------------

// File: rtl/dm_jtag_dtm.sv
// JTAG debug transport module: oversampled TAP with IDCODE/DTMCS/DMI/BYPASS
// registers, bridging DMI scans onto a single-outstanding valid/ready master.
module dm_jtag_dtm #(
  parameter logic [31:0] IDCODE      = 32'h0000_0001,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        tck,
  input  logic        tms,
  input  logic        tdi,
  output logic        tdo,
  output logic        dmi_valid,
  input  logic        dmi_ready,
  output logic        dmi_write,
  output logic [6:0]  dmi_addr,
  output logic [31:0] dmi_wdata,
  input  logic [31:0] dmi_rdata
);

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
  } tap_e;

  typedef enum logic {
    M_IDLE,
    M_REQ
  } mst_e;

  localparam logic [4:0] IR_IDCODE = 5'h01;
  localparam logic [4:0] IR_DTMCS  = 5'h10;
  localparam logic [4:0] IR_DMI    = 5'h11;

  logic [SYNC_STAGES-1:0] r_tck_s;
  logic [SYNC_STAGES-1:0] r_tms_s;
  logic [SYNC_STAGES-1:0] r_tdi_s;
  logic                   r_tck_prev;

  logic w_tck;
  logic w_tms;
  logic w_tdi;
  logic w_rise;
  logic w_fall;

  tap_e r_tap;
  tap_e w_tap_nxt;
  mst_e r_mst;
  mst_e w_mst_nxt;

  logic [4:0]  r_ir;
  logic [4:0]  r_ir_sr;
  logic [40:0] r_dr;
  logic        r_tdo;
  logic        r_sticky;
  logic        r_write;
  logic [6:0]  r_addr;
  logic [31:0] r_wdata;
  logic [6:0]  r_last_addr;
  logic [31:0] r_last_rdata;

  logic [40:0] w_dr_shift;
  logic [40:0] w_dr_cap;
  logic [31:0] w_dtmcs;
  logic [1:0]  w_stat;
  logic        w_pending;
  logic        w_cap_dr;
  logic        w_upd_dr;
  logic        w_req_op;
  logic        w_launch;
  logic        w_dmireset;
  logic        w_hardreset;
  logic        w_xfer;

  // Input synchronisers; tck edges are detected against the previous
  // synchronised sample.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_tck_s    <= '0;
      r_tms_s    <= '0;
      r_tdi_s    <= '0;
      r_tck_prev <= 1'b0;
    end else begin
      r_tck_s    <= {r_tck_s[SYNC_STAGES-2:0], tck};
      r_tms_s    <= {r_tms_s[SYNC_STAGES-2:0], tms};
      r_tdi_s    <= {r_tdi_s[SYNC_STAGES-2:0], tdi};
      r_tck_prev <= w_tck;
    end
  end

  assign w_tck  = r_tck_s[SYNC_STAGES-1];
  assign w_tms  = r_tms_s[SYNC_STAGES-1];
  assign w_tdi  = r_tdi_s[SYNC_STAGES-1];
  assign w_rise = w_tck & ~r_tck_prev;
  assign w_fall = ~w_tck & r_tck_prev;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_tap <= TLR;
    end else if (w_rise) begin
      r_tap <= w_tap_nxt;
    end
  end

  always_comb begin
    w_tap_nxt = r_tap;
    case (r_tap)
      TLR:    w_tap_nxt = w_tms ? TLR    : RTI;
      RTI:    w_tap_nxt = w_tms ? SEL_DR : RTI;
      SEL_DR: w_tap_nxt = w_tms ? SEL_IR : CAP_DR;
      CAP_DR: w_tap_nxt = w_tms ? EX1_DR : SH_DR;
      SH_DR:  w_tap_nxt = w_tms ? EX1_DR : SH_DR;
      EX1_DR: w_tap_nxt = w_tms ? UPD_DR : PA_DR;
      PA_DR:  w_tap_nxt = w_tms ? EX2_DR : PA_DR;
      EX2_DR: w_tap_nxt = w_tms ? UPD_DR : SH_DR;
      UPD_DR: w_tap_nxt = w_tms ? SEL_DR : RTI;
      SEL_IR: w_tap_nxt = w_tms ? TLR    : CAP_IR;
      CAP_IR: w_tap_nxt = w_tms ? EX1_IR : SH_IR;
      SH_IR:  w_tap_nxt = w_tms ? EX1_IR : SH_IR;
      EX1_IR: w_tap_nxt = w_tms ? UPD_IR : PA_IR;
      PA_IR:  w_tap_nxt = w_tms ? EX2_IR : PA_IR;
      EX2_IR: w_tap_nxt = w_tms ? UPD_IR : SH_IR;
      UPD_IR: w_tap_nxt = w_tms ? SEL_DR : RTI;
      default: w_tap_nxt = TLR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ir    <= IR_IDCODE;
      r_ir_sr <= 5'b00001;
    end else if (r_tap == TLR) begin
      r_ir <= IR_IDCODE;
    end else if (w_rise) begin
      case (r_tap)
        CAP_IR:  r_ir_sr <= 5'b00001;
        SH_IR:   r_ir_sr <= {w_tdi, r_ir_sr[4:1]};
        UPD_IR:  r_ir    <= r_ir_sr;
        default: r_ir_sr <= r_ir_sr;
      endcase
    end
  end

  assign w_pending = (r_mst == M_REQ);
  assign w_stat    = (r_sticky | w_pending) ? 2'b11 : 2'b00;
  assign w_dtmcs   = {17'd0, 3'd1, {2{r_sticky}}, 6'd7, 4'd1};

  // Shorter registers take tdi into their own MSB so they read back LSB first.
  always_comb begin
    w_dr_shift = r_dr;
    w_dr_cap   = '0;
    case (r_ir)
      IR_IDCODE: begin
        w_dr_shift = {9'd0, w_tdi, r_dr[31:1]};
        w_dr_cap   = {9'd0, IDCODE};
      end
      IR_DTMCS: begin
        w_dr_shift = {9'd0, w_tdi, r_dr[31:1]};
        w_dr_cap   = {9'd0, w_dtmcs};
      end
      IR_DMI: begin
        w_dr_shift = {w_tdi, r_dr[40:1]};
        w_dr_cap   = {r_last_addr, r_last_rdata, w_stat};
      end
      default: begin
        w_dr_shift = {40'd0, w_tdi};
        w_dr_cap   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_dr <= '0;
    end else if (w_rise) begin
      if (r_tap == CAP_DR) begin
        r_dr <= w_dr_cap;
      end else if (r_tap == SH_DR) begin
        r_dr <= w_dr_shift;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_tdo <= 1'b0;
    end else if (w_fall) begin
      if (r_tap == SH_DR) begin
        r_tdo <= r_dr[0];
      end else if (r_tap == SH_IR) begin
        r_tdo <= r_ir_sr[0];
      end else begin
        r_tdo <= 1'b0;
      end
    end
  end

  assign tdo = r_tdo;

  assign w_cap_dr    = w_rise && (r_tap == CAP_DR);
  assign w_upd_dr    = w_rise && (r_tap == UPD_DR);
  assign w_req_op    = w_upd_dr && (r_ir == IR_DMI)
                       && ((r_dr[1:0] == 2'd1) || (r_dr[1:0] == 2'd2));
  assign w_launch    = w_req_op && !r_sticky && !w_pending;
  assign w_dmireset  = w_upd_dr && (r_ir == IR_DTMCS) && r_dr[16];
  assign w_hardreset = w_upd_dr && (r_ir == IR_DTMCS) && r_dr[17];
  assign w_xfer      = w_pending && dmi_ready;

  // A busy response, seen either at capture or at update, latches sticky.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_sticky <= 1'b0;
    end else if (w_dmireset || w_hardreset) begin
      r_sticky <= 1'b0;
    end else if (w_pending && (w_req_op || (w_cap_dr && (r_ir == IR_DMI)))) begin
      r_sticky <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_mst <= M_IDLE;
    end else begin
      r_mst <= w_mst_nxt;
    end
  end

  always_comb begin
    w_mst_nxt = r_mst;
    case (r_mst)
      M_IDLE: if (w_launch) w_mst_nxt = M_REQ;
      M_REQ:  if (w_xfer || w_hardreset) w_mst_nxt = M_IDLE;
      default: w_mst_nxt = M_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_last_addr  <= '0;
      r_last_rdata <= '0;
    end else begin
      if (w_launch) begin
        r_write <= (r_dr[1:0] == 2'd2);
        r_addr  <= r_dr[40:34];
        r_wdata <= r_dr[33:2];
      end
      if (w_xfer) begin
        r_last_addr <= r_addr;
        if (!r_write) begin
          r_last_rdata <= dmi_rdata;
        end
      end
    end
  end

  assign dmi_valid = w_pending;
  assign dmi_write = r_write;
  assign dmi_addr  = r_addr;
  assign dmi_wdata = r_wdata;

endmodule

// File: tb/tb_dm_jtag_dtm.sv
// Directed bench for dm_jtag_dtm: bit-banged JTAG scans with a DMI
// transaction scoreboard checked by a responder-side monitor.
module tb_dm_jtag_dtm;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        tck = 1'b0;
  logic        tms = 1'b1;
  logic        tdi = 1'b0;
  logic        tdo;
  logic        dmi_valid;
  logic        dmi_ready = 1'b1;
  logic        dmi_write;
  logic [6:0]  dmi_addr;
  logic [31:0] dmi_wdata;
  logic [31:0] dmi_rdata = 32'h0;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    logic        w;
    logic [6:0]  a;
    logic [31:0] d;
  } txn_t;

  txn_t q[$];

  dm_jtag_dtm dut (
    .clk       (clk),
    .resetn    (resetn),
    .tck       (tck),
    .tms       (tms),
    .tdi       (tdi),
    .tdo       (tdo),
    .dmi_valid (dmi_valid),
    .dmi_ready (dmi_ready),
    .dmi_write (dmi_write),
    .dmi_addr  (dmi_addr),
    .dmi_wdata (dmi_wdata),
    .dmi_rdata (dmi_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (resetn && dmi_valid && dmi_ready) begin
      txn_t t;
      n_chk++;
      assert (q.size() > 0) n_pass++;
      else $error("FAIL unexp_xfer observed=addr %h expected=none", dmi_addr);
      if (q.size() > 0) begin
        t = q.pop_front();
        chk("xfer", {24'd0, dmi_write, dmi_addr, dmi_wdata},
            {24'd0, t.w, t.a, t.d});
      end
    end
  end

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic jt(input logic m, input logic d, output logic b);
    tms = m;
    tdi = d;
    wclk(2);
    b = tdo;
    tck = 1'b1;
    wclk(6);
    tck = 1'b0;
    wclk(6);
  endtask

  task automatic tap_reset();
    logic b;
    for (int i = 0; i < 5; i++) jt(1'b1, 1'b0, b);
    jt(1'b0, 1'b0, b);
  endtask

  task automatic shift_ir(input logic [4:0] ir, output logic [4:0] cap);
    logic b;
    jt(1'b1, 1'b0, b);
    jt(1'b1, 1'b0, b);
    jt(1'b0, 1'b0, b);
    jt(1'b0, 1'b0, b);
    for (int i = 0; i < 5; i++) begin
      jt(i == 4, ir[i], b);
      cap[i] = b;
    end
    jt(1'b1, 1'b0, b);
    jt(1'b0, 1'b0, b);
  endtask

  task automatic scan_dr(input int len, input logic [40:0] din,
                         output logic [40:0] dout);
    logic b;
    dout = '0;
    jt(1'b1, 1'b0, b);
    jt(1'b0, 1'b0, b);
    jt(1'b0, 1'b0, b);
    for (int i = 0; i < len; i++) begin
      jt(i == len - 1, din[i], b);
      dout[i] = b;
    end
    jt(1'b1, 1'b0, b);
    jt(1'b0, 1'b0, b);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  ic;
    logic [40:0] o;
    txn_t        t;

    wclk(4);
    chk("rst_tdo", {63'd0, tdo}, 64'd0);
    chk("rst_valid", {63'd0, dmi_valid}, 64'd0);
    chk("rst_write", {63'd0, dmi_write}, 64'd0);
    chk("rst_addr", {57'd0, dmi_addr}, 64'd0);
    chk("rst_wdata", {32'd0, dmi_wdata}, 64'd0);
    resetn = 1'b1;
    wclk(4);

    tap_reset();
    shift_ir(5'h01, ic);
    chk("ir_capture", {59'd0, ic}, 64'd1);
    scan_dr(32, '0, o);
    chk("idcode", {23'd0, o}, 64'h1);

    shift_ir(5'h1f, ic);
    scan_dr(2, 41'b01, o);
    chk("bypass", {23'd0, o}, 64'b10);

    shift_ir(5'h10, ic);
    scan_dr(32, '0, o);
    chk("dtmcs_idle", {23'd0, o}, 64'h1071);

    shift_ir(5'h11, ic);
    t = '{w: 1'b1, a: 7'h10, d: 32'h1};
    q.push_back(t);
    scan_dr(41, {7'h10, 32'h1, 2'd2}, o);
    chk("dmi_cap0", {23'd0, o}, 64'd0);
    wclk(20);
    chk("wr_done", q.size(), 0);
    chk("wr_held", {63'd0, dmi_write}, 64'd1);
    scan_dr(41, '0, o);
    chk("dmi_after_wr", {23'd0, o}, {23'd0, 7'h10, 32'h0, 2'd0});

    dmi_rdata = 32'hCAFE_F00D;
    t = '{w: 1'b0, a: 7'h04, d: 32'h0};
    q.push_back(t);
    scan_dr(41, {7'h04, 32'h0, 2'd1}, o);
    wclk(20);
    chk("rd_done", q.size(), 0);
    scan_dr(41, '0, o);
    chk("dmi_after_rd", {23'd0, o}, {23'd0, 7'h04, 32'hCAFE_F00D, 2'd0});

    @(posedge clk); #1;
    dmi_ready = 1'b0;
    dmi_rdata = 32'h1234_5678;
    t = '{w: 1'b0, a: 7'h05, d: 32'h0};
    q.push_back(t);
    scan_dr(41, {7'h05, 32'h0, 2'd1}, o);
    wclk(50);
    scan_dr(41, {7'h06, 32'h0, 2'd1}, o);
    chk("dmi_busy", {23'd0, o}, {23'd0, 7'h04, 32'hCAFE_F00D, 2'd3});
    chk("stall_valid", {63'd0, dmi_valid}, 64'd1);
    chk("stall_addr", {57'd0, dmi_addr}, 64'h05);
    shift_ir(5'h10, ic);
    scan_dr(32, '0, o);
    chk("dtmcs_sticky", {23'd0, o}, 64'h1C71);
    dmi_ready = 1'b1;
    wclk(20);
    chk("stall_done", q.size(), 0);
    scan_dr(32, 41'h1_0000, o);
    chk("dtmcs_clr_cap", {23'd0, o}, 64'h1C71);
    scan_dr(32, '0, o);
    chk("dtmcs_cleared", {23'd0, o}, 64'h1071);
    shift_ir(5'h11, ic);
    scan_dr(41, '0, o);
    chk("dmi_after_stall", {23'd0, o}, {23'd0, 7'h05, 32'h1234_5678, 2'd0});

    @(posedge clk); #1;
    dmi_ready = 1'b0;
    scan_dr(41, {7'h09, 32'h0, 2'd1}, o);
    chk("hr_pending", {63'd0, dmi_valid}, 64'd1);
    shift_ir(5'h10, ic);
    scan_dr(32, 41'h2_0000, o);
    wclk(2);
    chk("hr_abort", {63'd0, dmi_valid}, 64'd0);
    scan_dr(32, '0, o);
    chk("hr_dtmcs", {23'd0, o}, 64'h1071);

    shift_ir(5'h11, ic);
    scan_dr(41, {7'h07, 32'h0, 2'd1}, o);
    tap_reset();
    chk("tlr_keeps_req", {63'd0, dmi_valid}, 64'd1);
    chk("tlr_keeps_addr", {57'd0, dmi_addr}, 64'h07);
    resetn = 1'b0;
    wclk(1);
    chk("rst_mid_req", {63'd0, dmi_valid}, 64'd0);
    resetn = 1'b1;
    dmi_ready = 1'b1;
    wclk(4);
    jt(1'b0, 1'b0, ic[0]);
    scan_dr(32, '0, o);
    chk("ir_after_rst", {23'd0, o}, 64'h1);
    wclk(20);
    chk("q_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
